operand_fetch: RTL

- Issue/operand-fetch stage directly upstream of the 16x32 ARM register file.
- Accepts decoded instructions, drives both regfile read addresses, and captures the read data one cycle later.
- Corrects stale reads by forwarding from the writeback port and substitutes PC+8 for R15.
- Presents resolved operands to execute over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/operand_resolve.sv | 38 +++
 rtl/operand_fetch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared register-file geometry and PC-read constants. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int                  REG_W          = 4;
  localparam int                  DATA_W         = 32;
  localparam logic [REG_W-1:0]    PC_REG         = 4'd15;
  localparam logic [DATA_W-1:0]   PC_READ_OFFSET = 32'd8;

  // True when a writeback to wb_reg must overwrite a value sourced from src.
  function automatic logic wb_hits(input logic             wb_en,
                                   input logic [REG_W-1:0] wb_reg,
                                   input logic [REG_W-1:0] src);
    return wb_en && (wb_reg == src) && (src != PC_REG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_resolve.sv
// ---------------------------------------------------------------------------
// operand_resolve: priority mux R15 / live writeback / held / forward / regfile.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module operand_resolve
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0]  src_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              wb_en_i,
  input  logic [REG_W-1:0]  wb_reg_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              captured_i,
  input  logic [DATA_W-1:0] held_i,
  input  logic              fwd_i,
  input  logic [DATA_W-1:0] fwd_data_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] op_o
);

  always_comb begin
    op_o = rf_data_i;
    if (src_i == PC_REG) begin
      op_o = pc_i + PC_READ_OFFSET;
    end else if (wb_en_i && (wb_reg_i == src_i)) begin
      op_o = wb_data_i;
    end else if (captured_i) begin
      op_o = held_i;
    end else if (fwd_i) begin
      op_o = fwd_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch: two-slot operand fetch with writeback forwarding and PC+8.
// Optional stall counter via OPFETCH_STATS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module operand_fetch
  import cpu_pkg::*;
#(
  parameter int TAG_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rn,
  input  logic [REG_W-1:0]  in_rm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [REG_W-1:0]  rf_read_reg0,
  output logic [REG_W-1:0]  rf_read_reg1,
  input  logic [DATA_W-1:0] rf_read_data0,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op0,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_pc,
`ifdef OPFETCH_STATS_EN
  output logic [DATA_W-1:0] stall_cycles,
`endif
  output logic [TAG_W-1:0]  out_tag
);

  logic              a_valid_q, a_valid_d, a_cap_q, a_cap_d;
  logic              a_fwd0_q, a_fwd0_d, a_fwd1_q, a_fwd1_d;
  logic [REG_W-1:0]  a_rn_q, a_rn_d, a_rm_q, a_rm_d;
  logic [DATA_W-1:0] a_pc_q, a_pc_d, a_op0_q, a_op0_d, a_op1_q, a_op1_d;
  logic [DATA_W-1:0] a_fdat0_q, a_fdat0_d, a_fdat1_q, a_fdat1_d;
  logic [TAG_W-1:0]  a_tag_q, a_tag_d;

  logic              b_valid_q, b_valid_d;
  logic [REG_W-1:0]  b_rn_q, b_rn_d, b_rm_q, b_rm_d;
  logic [DATA_W-1:0] b_pc_q, b_pc_d, b_op0_q, b_op0_d, b_op1_q, b_op1_d;
  logic [TAG_W-1:0]  b_tag_q, b_tag_d;

  logic              w_a_to_b, w_accept;
  logic [DATA_W-1:0] w_res0, w_res1;

  assign rf_read_reg0 = in_rn;
  assign rf_read_reg1 = in_rm;

  operand_resolve u_res0 (
    .src_i      (a_rn_q),
    .pc_i       (a_pc_q),
    .wb_en_i    (wb_en),
    .wb_reg_i   (wb_reg),
    .wb_data_i  (wb_data),
    .captured_i (a_cap_q),
    .held_i     (a_op0_q),
    .fwd_i      (a_fwd0_q),
    .fwd_data_i (a_fdat0_q),
    .rf_data_i  (rf_read_data0),
    .op_o       (w_res0)
  );

  operand_resolve u_res1 (
    .src_i      (a_rm_q),
    .pc_i       (a_pc_q),
    .wb_en_i    (wb_en),
    .wb_reg_i   (wb_reg),
    .wb_data_i  (wb_data),
    .captured_i (a_cap_q),
    .held_i     (a_op1_q),
    .fwd_i      (a_fwd1_q),
    .fwd_data_i (a_fdat1_q),
    .rf_data_i  (rf_read_data1),
    .op_o       (w_res1)
  );

  always_comb begin
    w_a_to_b = a_valid_q && (!b_valid_q || out_ready);
    in_ready = !flush && (!a_valid_q || w_a_to_b);
    w_accept = in_valid && in_ready;

    a_valid_d = a_valid_q;  a_cap_d   = a_cap_q;
    a_fwd0_d  = a_fwd0_q;   a_fwd1_d  = a_fwd1_q;
    a_rn_d    = a_rn_q;     a_rm_d    = a_rm_q;
    a_pc_d    = a_pc_q;     a_tag_d   = a_tag_q;
    a_op0_d   = a_op0_q;    a_op1_d   = a_op1_q;
    a_fdat0_d = a_fdat0_q;  a_fdat1_d = a_fdat1_q;

    // The regfile returns pre-write data when written on the accept edge.
    if (flush) begin
      a_valid_d = 1'b0;
    end else if (w_accept) begin
      a_valid_d = 1'b1;
      a_cap_d   = 1'b0;
      a_rn_d    = in_rn;
      a_rm_d    = in_rm;
      a_pc_d    = in_pc;
      a_tag_d   = in_tag;
      a_fwd0_d  = wb_hits(wb_en, wb_reg, in_rn);
      a_fwd1_d  = wb_hits(wb_en, wb_reg, in_rm);
      a_fdat0_d = wb_data;
      a_fdat1_d = wb_data;
    end else if (w_a_to_b) begin
      a_valid_d = 1'b0;
    end else if (a_valid_q) begin
      a_cap_d = 1'b1;
      a_op0_d = w_res0;
      a_op1_d = w_res1;
    end

    b_valid_d = b_valid_q;
    b_rn_d    = b_rn_q;   b_rm_d  = b_rm_q;
    b_pc_d    = b_pc_q;   b_tag_d = b_tag_q;
    b_op0_d   = b_op0_q;  b_op1_d = b_op1_q;
    if (wb_hits(wb_en, wb_reg, b_rn_q)) b_op0_d = wb_data;
    if (wb_hits(wb_en, wb_reg, b_rm_q)) b_op1_d = wb_data;

    if (flush) begin
      b_valid_d = 1'b0;
    end else if (w_a_to_b) begin
      b_valid_d = 1'b1;
      b_rn_d    = a_rn_q;
      b_rm_d    = a_rm_q;
      b_pc_d    = a_pc_q;
      b_tag_d   = a_tag_q;
      b_op0_d   = w_res0;
      b_op1_d   = w_res1;
    end else if (out_ready) begin
      b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid_q <= 1'b0;  a_cap_q   <= 1'b0;
      a_fwd0_q  <= 1'b0;  a_fwd1_q  <= 1'b0;
      a_rn_q    <= '0;    a_rm_q    <= '0;
      a_pc_q    <= '0;    a_tag_q   <= '0;
      a_op0_q   <= '0;    a_op1_q   <= '0;
      a_fdat0_q <= '0;    a_fdat1_q <= '0;
      b_valid_q <= 1'b0;
      b_rn_q    <= '0;    b_rm_q    <= '0;
      b_pc_q    <= '0;    b_tag_q   <= '0;
      b_op0_q   <= '0;    b_op1_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;  a_cap_q   <= a_cap_d;
      a_fwd0_q  <= a_fwd0_d;   a_fwd1_q  <= a_fwd1_d;
      a_rn_q    <= a_rn_d;     a_rm_q    <= a_rm_d;
      a_pc_q    <= a_pc_d;     a_tag_q   <= a_tag_d;
      a_op0_q   <= a_op0_d;    a_op1_q   <= a_op1_d;
      a_fdat0_q <= a_fdat0_d;  a_fdat1_q <= a_fdat1_d;
      b_valid_q <= b_valid_d;
      b_rn_q    <= b_rn_d;     b_rm_q    <= b_rm_d;
      b_pc_q    <= b_pc_d;     b_tag_q   <= b_tag_d;
      b_op0_q   <= b_op0_d;    b_op1_q   <= b_op1_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_op0   = b_op0_q;
  assign out_op1   = b_op1_q;
  assign out_pc    = b_pc_q;
  assign out_tag   = b_tag_q;

`ifdef OPFETCH_STATS_EN
  logic [DATA_W-1:0] stall_q, stall_d;

  // Saturating count of cycles where execute refuses a valid result; flush leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (b_valid_q && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire
